// File: rtl/alu_req_arbiter.sv
// Round-robin front end for one shared combinational ALU: accept -> execute -> respond, 3 cycles per op.
// Requests stall (ready low) outside IDLE; RESP holds until the granted requester accepts. Optional ALU_ARB_STATS_EN adds grant counters.
module alu_req_arbiter #(
    parameter int SIZE  = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [1:0]           req_valid_i,
    output logic [1:0]           req_ready_o,
    input  logic [1:0][SIZE-1:0] req_a_i,
    input  logic [1:0][SIZE-1:0] req_b_i,
    input  logic [1:0][2:0]      req_mode_i,
    output logic [1:0]           rsp_valid_o,
    input  logic [1:0]           rsp_ready_i,
    output logic [SIZE-1:0]      rsp_s_o,
    output logic                 rsp_c_o,
    output logic [SIZE-1:0]      alu_a_o,
    output logic [SIZE-1:0]      alu_b_o,
    output logic [2:0]           alu_mode_o,
    input  logic [SIZE-1:0]      alu_s_i,
    input  logic                 alu_c_i,
`ifdef ALU_ARB_STATS_EN
    output logic [CNT_W-1:0]     grant_cnt0_o,
    output logic [CNT_W-1:0]     grant_cnt1_o,
`endif
    output logic                 busy_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic            id_q, id_d;
    logic [SIZE-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic [2:0]      mode_q, mode_d;
    logic            c_q, c_d;
    logic            sel;
    logic [1:0]      grant;

    // On contention the requester that did not win last time goes first.
    always_comb sel = (&req_valid_i) ? ~last_q : req_valid_i[1];

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        s_d         = s_q;
        c_d         = c_q;
        grant       = 2'b00;
        rsp_valid_o = 2'b00;
        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    grant[sel] = 1'b1;
                    a_d        = req_a_i[sel];
                    b_d        = req_b_i[sel];
                    mode_d     = req_mode_i[sel];
                    id_d       = sel;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                s_d     = alu_s_i;
                c_d     = alu_c_i;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_o[id_q] = 1'b1;
                if (rsp_ready_i[id_q]) begin
                    last_d  = id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is combinational, so mask it while reset is held.
    assign req_ready_o = grant & {2{~rst_i}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            s_q     <= s_d;
            c_q     <= c_d;
        end
    end

    assign alu_a_o    = a_q;
    assign alu_b_o    = b_q;
    assign alu_mode_o = mode_q;
    assign rsp_s_o    = s_q;
    assign rsp_c_o    = c_q;
    assign busy_o     = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (state_q == IDLE && |req_valid_i) begin
            if (!sel && !(&cnt0_q)) cnt0_q <= cnt0_q + 1'b1;
            if (sel && !(&cnt1_q))  cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign grant_cnt0_o = cnt0_q;
    assign grant_cnt1_o = cnt1_q;
`endif
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_alu_req_arbiter;
    localparam int SIZE  = 8;
    localparam int CNT_W = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [1:0][7:0] req_a = '0, req_b = '0;
    logic [1:0][2:0] req_mode = '0;
    logic [7:0]      rsp_s, alu_a, alu_b, alu_s;
    logic            rsp_c, alu_c, busy;
    logic [2:0]      alu_mode;
`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0, cnt1;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_req_arbiter #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_mode_i(req_mode),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_s_o(rsp_s), .rsp_c_o(rsp_c),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_mode_o(alu_mode),
        .alu_s_i(alu_s), .alu_c_i(alu_c),
`ifdef ALU_ARB_STATS_EN
        .grant_cnt0_o(cnt0), .grant_cnt1_o(cnt1),
`endif
        .busy_o(busy)
    );

    // Reference ALU: add/sub carry-out/borrow; other modes give an arbitrary carry to exercise pass-through.
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m);
        case (m)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {^b, a | b};
            3'd3:    return {^b, a & b};
            3'd4:    return {^a, a ^ b};
            3'd5:    return {^a, ~a};
            3'd6:    return {a[7], a << 1};
            default: return {a[0], a >> 1};
        endcase
    endfunction

    assign {alu_c, alu_s} = alu_f(alu_a, alu_b, alu_mode);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an op is either absent, executing (age 0) or awaiting response (age 1).
    bit       m_busy, m_last, m_id;
    int       m_age;
    bit [7:0] m_a, m_b, m_s;
    bit [2:0] m_mode;
    bit       m_c;
    int       m_cnt0, m_cnt1;
    int       sel, exp_ready, exp_rv;
    bit [8:0] r;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_ctl", {req_ready, rsp_valid, busy, alu_mode, rsp_c}, 0);
            chk("reset_dat", {alu_a, alu_b, rsp_s}, 0);
`ifdef ALU_ARB_STATS_EN
            chk("reset_cnt", {cnt0, cnt1}, 0);
`endif
            m_busy = 0; m_age = 0; m_last = 1; m_id = 0;
            m_a = 0; m_b = 0; m_mode = 0; m_s = 0; m_c = 0;
            m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            sel       = (req_valid == 2'b11) ? int'(!m_last) : int'(req_valid[1]);
            exp_ready = (!m_busy && req_valid != 0) ? (1 << sel) : 0;
            exp_rv    = (m_busy && m_age == 1) ? (1 << m_id) : 0;
            chk("req_ready", req_ready, exp_ready);
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("busy", busy, m_busy);
            chk("rsp_s", rsp_s, m_s);
            chk("rsp_c", rsp_c, m_c);
            chk("alu_ops", {alu_a, alu_b, alu_mode}, {m_a, m_b, m_mode});
`ifdef ALU_ARB_STATS_EN
            chk("grant_cnt", {cnt0, cnt1}, {m_cnt0[CNT_W-1:0], m_cnt1[CNT_W-1:0]});
`endif
            if (!m_busy) begin
                if (req_valid != 0) begin
                    m_busy = 1; m_age = 0; m_id = sel[0];
                    m_a = req_a[sel]; m_b = req_b[sel]; m_mode = req_mode[sel];
                    if (sel == 0) m_cnt0 = (m_cnt0 == (1 << CNT_W) - 1) ? m_cnt0 : m_cnt0 + 1;
                    else          m_cnt1 = (m_cnt1 == (1 << CNT_W) - 1) ? m_cnt1 : m_cnt1 + 1;
                end
            end else if (m_age == 0) begin
                r = alu_f(m_a, m_b, m_mode);
                m_s = r[7:0]; m_c = r[8]; m_age = 1;
            end else if (rsp_ready[m_id]) begin
                m_busy = 0; m_last = m_id;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] acc, hold;

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);

        // Single add from requester 0
        req_a[0] = 8'd200; req_b[0] = 8'd100; req_mode[0] = 3'b000;
        rsp_ready = 2'b11; req_valid = 2'b01;
        #1 chk("t1_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        chk("t1_busy", busy, 1);
        chk("t1_alu_a", alu_a, 200);
        tick();
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_s", rsp_s, 44);
        chk("t1_c", rsp_c, 1);
        tick();
        chk("t1_idle", busy, 0);

        // Subtract with wrap from requester 1
        req_a[1] = 8'd5; req_b[1] = 8'd7; req_mode[1] = 3'b001; req_valid = 2'b10;
        #1 chk("t2_ready", req_ready, 2'b10);
        tick(); req_valid = 2'b00;
        tick();
        chk("t2_rsp_valid", rsp_valid, 2'b10);
        chk("t2_s", rsp_s, 254);
        chk("t2_c", rsp_c, 1);
        tick();

        // Contention from reset: alternation starting with requester 0
        do_reset();
        req_a[0] = 8'd3; req_b[0] = 8'd4; req_mode[0] = 3'b011;
        req_a[1] = 8'd3; req_b[1] = 8'd4; req_mode[1] = 3'b010;
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk("t3_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
            tick();
            tick();
            chk("t3_rsp_valid", rsp_valid, (k % 2) ? 2'b10 : 2'b01);
            chk("t3_s", rsp_s, (k % 2) ? 7 : 0);
            tick();
        end

        // Backpressure in RESP; non-granted rsp_ready must be ignored
        req_a[0] = 8'd9; req_b[0] = 8'd9; req_mode[0] = 3'b000;
        req_valid = 2'b01; rsp_ready = 2'b00;
        tick();
        tick();
        rsp_ready = 2'b10;
        for (int k = 0; k < 5; k++) begin
            chk("t4_rsp_valid", rsp_valid, 2'b01);
            chk("t4_s", rsp_s, 18);
            chk("t4_c", rsp_c, 0);
            chk("t4_ready", req_ready, 2'b00);
            chk("t4_busy", busy, 1);
            tick();
        end
        rsp_ready = 2'b01; req_valid = 2'b00;
        tick();
        chk("t4_release", {busy, rsp_valid}, 0);

        // Async reset during EXEC
        req_a[1] = 8'd77; req_b[1] = 8'd1; req_mode[1] = 3'b100; req_valid = 2'b10;
        tick();
        req_valid = 2'b11;
        rst = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_outs", {req_ready, rsp_valid, alu_mode, rsp_c}, 0);
        chk("t5_dat", {alu_a, rsp_s}, 0);
        tick();
        tick();
        rst = 1'b0;
        #1 chk("t5_first_grant", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        tick();
        chk("t5_rsp_valid", rsp_valid, 2'b01);
        tick();

`ifdef ALU_ARB_STATS_EN
        // Five grants to requester 0 saturate a 2-bit counter
        do_reset();
        rsp_ready = 2'b11; req_valid = 2'b01;
        repeat (15) tick();
        req_valid = 2'b00;
        tick();
        chk("t6_cnt0", cnt0, 3);
        chk("t6_cnt1", cnt1, 0);
`endif

        // Randomized traffic: requesters hold valid/data until accepted, with rare drops
        do_reset();
        hold = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                do_reset();
                hold = 2'b00;
            end
            for (int i = 0; i < 2; i++) begin
                if (!hold[i] || ($urandom_range(49) == 0)) begin
                    req_valid[i] = ($urandom_range(2) != 0);
                    req_a[i]     = 8'($urandom);
                    req_b[i]     = 8'($urandom);
                    req_mode[i]  = 3'($urandom);
                end
                hold[i] = req_valid[i];
            end
            rsp_ready = 2'($urandom);
            #1 acc = req_valid & req_ready;
            tick();
            hold = hold & ~acc;
        end
        req_valid = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
